// File: rtl/swd_frame_sequencer_if.sv
// Command/response bus of the SWD frame sequencer.
// The master side issues SWD transactions and accepts responses.
// The slave side is the sequencer itself.
`timescale 1ns/1ps
interface swd_frame_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_req;
    logic        cmd_rnw;
    logic [31:0] cmd_wdata;
    logic        cmd_raw;
    logic [4:0]  cmd_raw_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_parity_err;

    modport master (
        output cmd_valid, cmd_req, cmd_rnw, cmd_wdata, cmd_raw, cmd_raw_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
    );

    modport slave (
        input  cmd_valid, cmd_req, cmd_rnw, cmd_wdata, cmd_raw, cmd_raw_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
    );
endinterface

// File: rtl/swd_frame_sequencer.sv
// SWD frame sequencer: drives one 48-bit frame into the SPI-style SWD bridge
// per command and deserialises the bridge's miso into ACK, data and parity.
// Optional RAW mode (macro SWD_SEQ_RAW_EN) holds the bridge in passthrough and
// shifts a 1..32-bit pattern for line resets and JTAG-to-SWD sequences.
// sck is derived from clk; each sck phase lasts CLK_DIV clk cycles.
`timescale 1ns/1ps
module swd_frame_sequencer #(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    swd_frame_sequencer_if.slave  bus,
    output logic                  busy,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  bridge_rst_n,
    output logic                  rnw
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("swd_frame_sequencer: CLK_DIV must be at least 2");
    end

    localparam int              DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]      FRAME_LAST = 6'd47;

`ifdef SWD_SEQ_RAW_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, RESP = 2'd2, RAW = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, RESP = 2'd2} state_t;
`endif

    state_t            state_q, state_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic [5:0]        bit_q, bit_n;
    logic              sck_q, sck_n;
    logic              mosi_q, mosi_n;
    logic              brst_q, brst_n;
    logic              rnw_q, rnw_n;
    logic              ready_q, ready_n;
    logic [7:0]        req_q, req_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [2:0]        ack_q, ack_n;
    logic [31:0]       rdata_q, rdata_n;
    logic              par_q, par_n;
    logic [2:0]        rsp_ack_q, rsp_ack_n;
    logic [31:0]       rsp_rdata_q, rsp_rdata_n;
    logic              rsp_perr_q, rsp_perr_n;
    logic              in_raw;
    logic [5:0]        last_idx;
    logic [5:0]        next_idx;
    logic              read_ok;
`ifdef SWD_SEQ_RAW_EN
    logic [4:0]        raw_len_q, raw_len_n;
`endif

    // mosi level for each frame bit: request byte, turnaround gaps, write data and its parity
    function automatic logic frame_bit(input logic [5:0] idx, input logic [7:0] req,
                                       input logic rd, input logic [31:0] wd);
        logic b;
        b = 1'b0;
        if (idx >= 6'd2 && idx <= 6'd9)
            b = req[3'(idx - 6'd2)];
        else if (idx >= 6'd14 && idx <= 6'd45)
            b = rd ? 1'b0 : wd[5'(idx - 6'd14)];
        else if (idx == 6'd46)
            b = rd ? 1'b0 : ^wd;
        return b;
    endfunction

    // Mode decode: whether a RAW sequence is running and which bit index ends it
    always_comb begin
`ifdef SWD_SEQ_RAW_EN
        in_raw   = (state_q == RAW);
        last_idx = in_raw ? {1'b0, raw_len_q} : FRAME_LAST;
`else
        in_raw   = 1'b0;
        last_idx = FRAME_LAST;
`endif
    end

    // Next-state and datapath: accept a command, time the sck phases, shift mosi, capture miso
    always_comb begin
        state_n     = state_q;
        div_n       = div_q;
        bit_n       = bit_q;
        sck_n       = sck_q;
        mosi_n      = mosi_q;
        brst_n      = brst_q;
        rnw_n       = rnw_q;
        req_n       = req_q;
        wdata_n     = wdata_q;
        ack_n       = ack_q;
        rdata_n     = rdata_q;
        par_n       = par_q;
        rsp_ack_n   = rsp_ack_q;
        rsp_rdata_n = rsp_rdata_q;
        rsp_perr_n  = rsp_perr_q;
`ifdef SWD_SEQ_RAW_EN
        raw_len_n   = raw_len_q;
`endif
        next_idx    = bit_q + 6'd1;
        read_ok     = rnw_q && (ack_q == 3'b001);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    req_n   = bus.cmd_req;
                    rnw_n   = bus.cmd_rnw;
                    wdata_n = bus.cmd_wdata;
                    div_n   = '0;
                    bit_n   = '0;
                    sck_n   = 1'b0;
                    ack_n   = '0;
                    rdata_n = '0;
                    par_n   = 1'b0;
                    state_n = FRAME;
                    brst_n  = 1'b1;
                    mosi_n  = 1'b0;
`ifdef SWD_SEQ_RAW_EN
                    raw_len_n = bus.cmd_raw_len;
                    if (bus.cmd_raw) begin
                        state_n = RAW;
                        brst_n  = 1'b0;
                        mosi_n  = bus.cmd_wdata[0];
                    end
`endif
                end
            end

`ifdef SWD_SEQ_RAW_EN
            FRAME, RAW: begin
`else
            FRAME: begin
`endif
                if (div_q == DIV_LAST) begin
                    div_n = '0;
                    if (!sck_q) begin
                        sck_n = 1'b1;
                        if (in_raw)
                            rdata_n[bit_q[4:0]] = miso;
                        else if (bit_q >= 6'd11 && bit_q <= 6'd13)
                            ack_n[2'(bit_q - 6'd11)] = miso;
                        else if (bit_q >= 6'd14 && bit_q <= 6'd45)
                            rdata_n[5'(bit_q - 6'd14)] = miso;
                        else if (bit_q == 6'd46)
                            par_n = miso;
                    end else begin
                        sck_n = 1'b0;
                        if (bit_q == last_idx) begin
                            state_n = RESP;
                            brst_n  = 1'b0;
                            mosi_n  = 1'b0;
                            if (in_raw) begin
                                rsp_ack_n   = 3'b000;
                                rsp_rdata_n = rdata_q;
                                rsp_perr_n  = 1'b0;
                            end else begin
                                rsp_ack_n   = ack_q;
                                rsp_rdata_n = read_ok ? rdata_q : 32'h0;
                                rsp_perr_n  = read_ok && ((^rdata_q) != par_q);
                            end
                        end else begin
                            bit_n  = next_idx;
                            mosi_n = in_raw ? wdata_q[next_idx[4:0]]
                                            : frame_bit(next_idx, req_q, rnw_q, wdata_q);
                        end
                    end
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end

            RESP: begin
                if (bus.rsp_ready)
                    state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase

        ready_n = (state_n == IDLE);
    end

    // State register with synchronous active-low reset to the idle, passthrough bridge state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            brst_q      <= 1'b0;
            rnw_q       <= 1'b1;
            ready_q     <= 1'b0;
            req_q       <= '0;
            wdata_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            par_q       <= 1'b0;
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
`ifdef SWD_SEQ_RAW_EN
            raw_len_q   <= '0;
`endif
        end else begin
            state_q     <= state_n;
            div_q       <= div_n;
            bit_q       <= bit_n;
            sck_q       <= sck_n;
            mosi_q      <= mosi_n;
            brst_q      <= brst_n;
            rnw_q       <= rnw_n;
            ready_q     <= ready_n;
            req_q       <= req_n;
            wdata_q     <= wdata_n;
            ack_q       <= ack_n;
            rdata_q     <= rdata_n;
            par_q       <= par_n;
            rsp_ack_q   <= rsp_ack_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_perr_q  <= rsp_perr_n;
`ifdef SWD_SEQ_RAW_EN
            raw_len_q   <= raw_len_n;
`endif
        end
    end

    assign bus.cmd_ready      = ready_q;
    assign bus.rsp_valid      = (state_q == RESP);
    assign bus.rsp_ack        = rsp_ack_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_parity_err = rsp_perr_q;
    assign busy               = (state_q == FRAME) || in_raw;
    assign sck                = sck_q;
    assign mosi               = mosi_q;
    assign bridge_rst_n       = brst_q;
    assign rnw                = rnw_q;

endmodule

// File: tb/tb_swd_frame_sequencer.sv
// Self-checking bench for swd_frame_sequencer with a behavioural bridge model.
// The model records mosi and serves miso per sck rise; expected frames and
// responses are built from the frame layout with plain vector arithmetic.
// RAW tests are compiled only when SWD_SEQ_RAW_EN is defined.
`timescale 1ns/1ps
module tb_swd_frame_sequencer;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, sck, mosi, miso, bridge_rst_n, rnw;

    swd_frame_sequencer_if bus();

    swd_frame_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .busy         (busy),
        .sck          (sck),
        .mosi         (mosi),
        .miso         (miso),
        .bridge_rst_n (bridge_rst_n),
        .rnw          (rnw)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Bridge model state
    int          bit_cnt = 0;
    logic [63:0] mosi_log = '0;
    logic [63:0] miso_vec = '0;
    logic        loopback = 1'b0;
    logic        exp_brst = 1'b1;
    int          brst_bad = 0;

    // Bridge model: records mosi and checks bridge_rst_n on every sck rise
    always @(posedge sck) begin
        if (bit_cnt < 64) mosi_log[bit_cnt] = mosi;
        if (bridge_rst_n !== exp_brst) brst_bad++;
        bit_cnt++;
    end

    assign miso = loopback ? mosi : miso_vec[bit_cnt[5:0]];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one command and returns right after the handshake edge
    task automatic applyStimulus(input logic [7:0] req, input logic rd, input logic [31:0] wdata,
                                 input logic raw, input logic [4:0] raw_len);
        int n;
        @(negedge clk);
        bus.cmd_req     = req;
        bus.cmd_rnw     = rd;
        bus.cmd_wdata   = wdata;
        bus.cmd_raw     = raw;
        bus.cmd_raw_len = raw_len;
        bus.cmd_valid   = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready_wait", (n < 1000), 1'b1);
        bit_cnt  = 0;
        mosi_log = '0;
        brst_bad = 0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("busy_in_flight", busy, 1'b1);
        checkOutput("cmd_ready_in_flight", bus.cmd_ready, 1'b0);
        checkOutput("rnw_latched", rnw, rd);
    endtask

    // Waits (bounded) for rsp_valid; lat is the cycle index relative to the handshake cycle 0
    task automatic waitResponse(output int lat);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Holds the response a random number of cycles, then consumes it
    task automatic consumeResponse(input logic [31:0] exp_rdata);
        int hold;
        hold = $urandom_range(0, 3);
        checkOutput("gap_sck_low", sck, 1'b0);
        checkOutput("gap_bridge_rst_low", bridge_rst_n, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("rsp_valid_held", bus.rsp_valid, 1'b1);
            checkOutput("rsp_rdata_held", bus.rsp_rdata, exp_rdata);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_valid_pulse_end", bus.rsp_valid, 1'b0);
        checkOutput("cmd_ready_after_rsp", bus.cmd_ready, 1'b1);
    endtask

    // One 48-bit frame checked against the frame layout and response rules
    task automatic runFrame(input logic [7:0] req, input logic rd, input logic [31:0] wdata,
                            input logic [2:0] ack, input logic [31:0] data, input logic par,
                            input logic raw);
        int          lat;
        logic [47:0] exp_mosi;
        logic        ok;
        logic [31:0] exp_rdata;
        miso_vec          = {$urandom, $urandom};
        miso_vec[13:11]   = ack;
        miso_vec[45:14]   = data;
        miso_vec[46]      = par;
        loopback          = 1'b0;
        exp_brst          = 1'b1;
        exp_mosi          = '0;
        exp_mosi[9:2]     = req;
        if (!rd) begin
            exp_mosi[45:14] = wdata;
            exp_mosi[46]    = ^wdata;
        end
        ok        = rd && (ack == 3'b001);
        exp_rdata = ok ? data : 32'h0;
        applyStimulus(req, rd, wdata, raw, 5'($urandom));
        waitResponse(lat);
        checkOutput("frame_latency", lat, 96 * CLK_DIV + 1);
        checkOutput("frame_bit_count", bit_cnt, 48);
        checkOutput("frame_mosi", mosi_log[47:0], exp_mosi);
        checkOutput("frame_mosi_req", mosi_log[9:2], req);
        checkOutput("frame_bridge_rst", brst_bad, 0);
        checkOutput("rsp_ack", bus.rsp_ack, ack);
        checkOutput("rsp_rdata", bus.rsp_rdata, exp_rdata);
        checkOutput("rsp_parity_err", bus.rsp_parity_err, ok && ((^data) != par));
        consumeResponse(exp_rdata);
    endtask

`ifdef SWD_SEQ_RAW_EN
    // One RAW sequence with miso looped back to mosi
    task automatic runRaw(input logic [31:0] pattern, input logic [4:0] len);
        int          lat;
        int          nbits;
        logic [63:0] mask;
        nbits    = int'(len) + 1;
        mask     = (64'd1 << nbits) - 64'd1;
        loopback = 1'b1;
        exp_brst = 1'b0;
        applyStimulus(8'($urandom), 1'($urandom), pattern, 1'b1, len);
        checkOutput("raw_bridge_rst_start", bridge_rst_n, 1'b0);
        waitResponse(lat);
        checkOutput("raw_latency", lat, 2 * nbits * CLK_DIV + 1);
        checkOutput("raw_bit_count", bit_cnt, nbits);
        checkOutput("raw_bridge_rst", brst_bad, 0);
        checkOutput("raw_rdata", bus.rsp_rdata, {32'h0, pattern} & mask);
        checkOutput("raw_ack", bus.rsp_ack, 3'b000);
        checkOutput("raw_parity_err", bus.rsp_parity_err, 1'b0);
        consumeResponse(32'({32'h0, pattern} & mask));
        loopback = 1'b0;
    endtask
`endif

    // Checks every output against its reset value
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sck"}, sck, 1'b0);
        checkOutput({tag, "_mosi"}, mosi, 1'b0);
        checkOutput({tag, "_bridge_rst_n"}, bridge_rst_n, 1'b0);
        checkOutput({tag, "_rnw"}, rnw, 1'b1);
        checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        checkOutput({tag, "_rsp_ack"}, bus.rsp_ack, 3'b000);
        checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        checkOutput({tag, "_rsp_parity_err"}, bus.rsp_parity_err, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence
    initial begin
        int          n;
        int          seen;
        logic [2:0]  acks [4];
        logic [31:0] d;

        bus.cmd_valid   = 1'b0;
        bus.cmd_req     = '0;
        bus.cmd_rnw     = 1'b0;
        bus.cmd_wdata   = '0;
        bus.cmd_raw     = 1'b0;
        bus.cmd_raw_len = '0;
        bus.rsp_ready   = 1'b0;
        acks[0] = 3'b001; acks[1] = 3'b010; acks[2] = 3'b100; acks[3] = 3'b111;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

        $display("[TB] read OK");
        runFrame(8'hA5, 1'b1, 32'h0, 3'b001, 32'h12345678, ^32'h12345678, 1'b0);
        $display("[TB] read WAIT");
        runFrame(8'hB1, 1'b1, 32'h0, 3'b010, 32'hDEADBEEF, 1'b1, 1'b0);
        $display("[TB] parity error");
        runFrame(8'h8D, 1'b1, 32'h0, 3'b001, 32'h00000001, 1'b0, 1'b0);
        $display("[TB] write");
        runFrame(8'hA9, 1'b0, 32'hCAFEF00D, 3'b001, 32'h0, 1'b0, 1'b0);

`ifdef SWD_SEQ_RAW_EN
        $display("[TB] RAW sequences");
        runRaw(32'h0000A5C3, 5'd15);
        runRaw($urandom, 5'd0);
        runRaw($urandom, 5'd31);
        runRaw($urandom, 5'($urandom));
`else
        $display("[TB] cmd_raw ignored without RAW support");
        runFrame(8'hC5, 1'b1, 32'h0, 3'b001, 32'h0BADF00D, ^32'h0BADF00D, 1'b1);
`endif

        $display("[TB] reset mid-frame");
        miso_vec = {$urandom, $urandom};
        exp_brst = 1'b1;
        applyStimulus(8'h5A, 1'b1, 32'h0, 1'b0, 5'd0);
        n = 0;
        while (bit_cnt < 20 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_bit20", (n < 5000), 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("midreset");
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 96 * CLK_DIV + 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        checkOutput("no_rsp_after_reset", seen, 0);
        checkOutput("no_sck_after_reset", bit_cnt, 20);
        runFrame(8'h87, 1'b1, 32'h0, 3'b001, 32'hA5A55A5A, ^32'hA5A55A5A, 1'b0);

        $display("[TB] random frames");
        for (int t = 0; t < 6; t++) begin
            d = $urandom;
            runFrame(8'($urandom), 1'($urandom), $urandom, acks[$urandom_range(0, 3)], d,
                     1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
